// File: rtl/mac_array_param.sv
// Parametrised NCH-lane K-tap multiply-accumulate array with a shared coefficient
// stream, valid/ready handshakes on both sides and saturated per-lane results.
//
// state | meaning
// IDLE  | waiting for start, no handshakes accepted
// RUN   | accepting sample columns, one result vector per K accepts
// DRAIN | NOUT results formed, waiting for the last one to be taken
module mac_array_param #(
  parameter int NCH    = 4,
  parameter int DW     = 8,
  parameter int CW     = 7,
  parameter int K      = 8,
  parameter int NOUT   = 32,
  parameter int OW     = 18,
  parameter int SIGNED = 0,
  localparam int AW    = $clog2(K),
  localparam int ACCW  = DW + CW + AW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [NCH*DW-1:0]   x_data_i,
  output logic [AW-1:0]       coef_addr_o,
  input  logic [CW-1:0]       coef_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [NCH*OW-1:0]   out_data_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int CNTW = $clog2(NOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t              state_q;
  logic [AW-1:0]       tap_q;
  logic [CNTW-1:0]     cnt_q;
  logic [NCH*ACCW-1:0] acc_q;
  logic [NCH*OW-1:0]   out_data_q;
  logic                out_valid_q;
  logic                done_q;

  logic [NCH*ACCW-1:0] sum_w;
  logic [NCH*OW-1:0]   sat_w;
  logic                accept_w;
  logic                pop_w;
  logic                last_tap_w;
  logic                last_out_w;

  // A pending result blocks new samples unless it leaves this same cycle.
  assign in_ready_o = (state_q == S_RUN) && (!out_valid_q || out_ready_i);
  assign accept_w   = in_valid_i && in_ready_o;
  assign pop_w      = out_valid_q && out_ready_i;
  assign last_tap_w = (tap_q == AW'(K - 1));
  assign last_out_w = (cnt_q == CNTW'(NOUT - 1));

  for (genvar c = 0; c < NCH; c++) begin : g_lane
    logic [DW-1:0]   x_c;
    logic [ACCW-1:0] x_ext;
    logic [ACCW-1:0] c_ext;
    logic [ACCW-1:0] prod;
    logic [ACCW-1:0] sum;
    logic [OW-1:0]   sat;

    assign x_c = x_data_i[c*DW +: DW];

    if (SIGNED != 0) begin : g_sext
      assign x_ext = {{(ACCW-DW){x_c[DW-1]}}, x_c};
      assign c_ext = {{(ACCW-CW){coef_data_i[CW-1]}}, coef_data_i};
    end else begin : g_zext
      assign x_ext = {{(ACCW-DW){1'b0}}, x_c};
      assign c_ext = {{(ACCW-CW){1'b0}}, coef_data_i};
    end

    // The low ACCW bits of the product are the same for signed and unsigned operands.
    assign prod = x_ext * c_ext;
    assign sum  = acc_q[c*ACCW +: ACCW] + prod;

    if (OW == ACCW) begin : g_nosat
      assign sat = sum;
    end else if (SIGNED != 0) begin : g_ssat
      logic ovf;
      assign ovf = (sum[ACCW-1:OW-1] != {(ACCW-OW+1){sum[ACCW-1]}});
      assign sat = !ovf          ? sum[OW-1:0] :
                   sum[ACCW-1]   ? {1'b1, {(OW-1){1'b0}}} :
                                   {1'b0, {(OW-1){1'b1}}};
    end else begin : g_usat
      assign sat = (|sum[ACCW-1:OW]) ? {OW{1'b1}} : sum[OW-1:0];
    end

    assign sum_w[c*ACCW +: ACCW] = sum;
    assign sat_w[c*OW +: OW]     = sat;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else if (abort_i) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (pop_w) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_RUN;
            tap_q   <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
          end
        end
        S_RUN: begin
          if (accept_w) begin
            if (last_tap_w) begin
              out_data_q  <= sat_w;
              out_valid_q <= 1'b1;
              acc_q       <= '0;
              tap_q       <= '0;
              cnt_q       <= cnt_q + CNTW'(1);
              if (last_out_w) begin
                state_q <= S_DRAIN;
              end
            end else begin
              acc_q <= sum_w;
              tap_q <= tap_q + AW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (pop_w) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign coef_addr_o = tap_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = done_q;

endmodule

// File: tb/tb_mac_array_param.sv
// Bench for mac_array_param: unsigned default instance with a reference model,
// plus a small signed instance exercising both saturation rails.
module tb_mac_array_param;
  localparam int NCH = 4, DW = 8, CW = 7, K = 8, NOUT = 32, OW = 18, SOW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               start_i = 1'b0, abort_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b0;
  logic [NCH*DW-1:0]  x_data_i = '0;
  logic [2:0]         coef_addr_o;
  logic [CW-1:0]      coef_data_i;
  logic               in_ready_o, out_valid_o, busy_o, done_o;
  logic [NCH*OW-1:0]  out_data_o;

  logic [CW-1:0]      rom [K];
  logic               use_const = 1'b1;
  logic [CW-1:0]      const_coef = '0;
  assign coef_data_i = use_const ? const_coef : rom[coef_addr_o];

  logic               start_b = 1'b0, abort_b = 1'b0, in_valid_b = 1'b0, out_ready_b = 1'b1;
  logic [NCH*DW-1:0]  x_b = '0;
  logic [CW-1:0]      coef_b = '0;
  logic [2:0]         coef_addr_b;
  logic               in_ready_b, out_valid_b, busy_b, done_b;
  logic [NCH*SOW-1:0] out_data_b;

  mac_array_param #(.NCH(NCH), .DW(DW), .CW(CW), .K(K), .NOUT(NOUT), .OW(OW), .SIGNED(0)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .x_data_i(x_data_i),
    .coef_addr_o(coef_addr_o), .coef_data_i(coef_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .busy_o(busy_o), .done_o(done_o));

  mac_array_param #(.NCH(NCH), .DW(DW), .CW(CW), .K(K), .NOUT(2), .OW(SOW), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start_i(start_b), .abort_i(abort_b),
    .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .x_data_i(x_b),
    .coef_addr_o(coef_addr_b), .coef_data_i(coef_b),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_b), .out_data_o(out_data_b),
    .busy_o(busy_b), .done_o(done_b));

  int checks = 0, errors = 0, done_cnt = 0;
  always @(negedge clk) if (done_o) done_cnt++;

  longint            m_acc [NCH];
  int                m_tap, npop, total_acc, guard;
  logic [NCH*OW-1:0] q [$];
  bit                drain_watch = 1'b0, drain_checked = 1'b0;
  int                acc_before;

  typedef struct {
    logic [NCH*DW-1:0] x;
    logic [CW-1:0]     coef;
    logic [NCH*OW-1:0] exp;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic reset_model();
    foreach (m_acc[c]) m_acc[c] = 0;
    m_tap = 0; npop = 0; total_acc = 0;
    q.delete();
  endtask

  // One cycle on the unsigned instance: drive, observe handshakes, advance the model.
  task automatic step(input logic v, input logic [NCH*DW-1:0] x, input logic r);
    logic acc, pop;
    logic [NCH*OW-1:0] e;
    logic [CW-1:0] cf;
    in_valid_i = v; x_data_i = x; out_ready_i = r;
    #1;
    acc = in_valid_i && in_ready_o;
    pop = out_valid_o && out_ready_i;
    if (pop) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected got result %0h want none", out_data_o);
      end else begin
        e = q.pop_front();
        chk("sb_result", out_data_o, e);
      end
      npop++;
    end
    if (acc) begin
      chk("coef_addr", 128'(coef_addr_o), 128'(m_tap));
      cf = use_const ? const_coef : rom[m_tap];
      for (int c = 0; c < NCH; c++) m_acc[c] += longint'(x[c*DW +: DW]) * longint'(cf);
      total_acc++;
      if (m_tap == K-1) begin
        for (int c = 0; c < NCH; c++) begin
          e[c*OW +: OW] = (m_acc[c] > longint'((1 << OW) - 1)) ? {OW{1'b1}} : OW'(m_acc[c]);
          m_acc[c] = 0;
        end
        q.push_back(e);
        m_tap = 0;
      end else begin
        m_tap++;
      end
    end
    @(posedge clk); #1;
    if (drain_watch && !drain_checked && total_acc == NOUT*K) begin
      chk("in_ready_drain", in_ready_o, 1'b0);
      drain_checked = 1'b1;
    end
  endtask

  task automatic start_run();
    start_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("start_busy", busy_o, 1'b1);
    chk("start_in_ready", in_ready_o, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 7'd127, {4{18'd259080}}};
    tbl[1] = '{32'h0403_0201, 7'd10,  {18'd320, 18'd240, 18'd160, 18'd80}};
    tbl[2] = '{32'h0000_0000, 7'd127, 72'd0};
    tbl[3] = '{32'h0180_00FF, 7'd1,   {18'd8, 18'd1024, 18'd0, 18'd2040}};
    for (int a = 0; a < K; a++) rom[a] = 7'(3 + 17*a);
    reset_model();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready_o, 1'b0);
    chk("rst_coef_addr", coef_addr_o, 3'd0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    chk("rst_out_data", out_data_o, '0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Signed instance: rails at +2047 and -2048 plus in-range lanes.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    chk("s_in_ready", in_ready_b, 1'b1);
    x_b = 32'h05FF_0180; coef_b = 7'h40; in_valid_b = 1'b1;
    repeat (K) @(posedge clk);
    #1;
    chk("s_valid1", out_valid_b, 1'b1);
    chk("s_data1", out_data_b, {12'h800, 12'h200, 12'hE00, 12'h7FF});
    chk("s_coef_addr", coef_addr_b, 3'd0);
    x_b = 32'hFD02_8080; coef_b = 7'h3F;
    repeat (K) @(posedge clk);
    #1;
    chk("s_valid2", out_valid_b, 1'b1);
    chk("s_data2", out_data_b, {12'hA18, 12'h3F0, 12'h800, 12'h800});
    chk("s_drain_ready", in_ready_b, 1'b0);
    in_valid_b = 1'b0;
    @(posedge clk); #1;
    chk("s_done", done_b, 1'b1);
    chk("s_busy", busy_b, 1'b0);

    // Run 1: full-rate table, backpressure, then random gaps to completion.
    drain_watch = 1'b1;
    start_run();
    for (int i = 0; i < 4; i++) begin
      const_coef = tbl[i].coef;
      acc_before = total_acc;
      for (int t = 0; t < K; t++) step(1'b1, tbl[i].x, 1'b1);
      chk("tbl_no_bubble", 128'(total_acc - acc_before), 128'(K));
      chk("tbl_valid", out_valid_o, 1'b1);
      chk("tbl_data", out_data_o, tbl[i].exp);
    end

    const_coef = 7'd100;
    for (int t = 0; t < K; t++) step(1'b1, 32'hC8C8_C8C8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hC8C8_C8C8, 1'b0);
      chk("bp_in_ready", in_ready_o, 1'b0);
      chk("bp_valid", out_valid_o, 1'b1);
      chk("bp_data", out_data_o, {4{18'd160000}});
      chk("bp_tap", coef_addr_o, 3'd0);
    end

    use_const = 1'b0;
    for (int a = 0; a < K; a++) rom[a] = 7'($urandom);
    guard = 0;
    while (npop < NOUT && guard < 4000) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("run1_results", 128'(npop), 128'(NOUT));
    chk("run1_accepts", 128'(total_acc), 128'(NOUT*K));
    chk("done_pulse", done_o, 1'b1);
    chk("done_busy", busy_o, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("done_single", done_o, 1'b0);
    chk("done_count", 128'(done_cnt), 128'd1);
    drain_watch = 1'b0;

    // Run 2: abort at tap 3 of result 5.
    reset_model();
    start_run();
    for (int i = 0; i < 4*K + 3; i++) step(1'b1, $urandom, 1'b1);
    chk("abort_pre_tap", coef_addr_o, 3'd3);
    chk("abort_pre_results", 128'(npop), 128'd4);
    abort_i = 1'b1; in_valid_i = 1'b0;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_valid", out_valid_o, 1'b0);
    chk("abort_in_ready", in_ready_o, 1'b0);
    chk("abort_tap", coef_addr_o, 3'd0);
    reset_model();
    repeat (3) step(1'b0, '0, 1'b1);
    chk("abort_no_done", 128'(done_cnt), 128'd1);

    // Run 3: fresh start after abort, then async reset mid-dot-product.
    start_run();
    for (int i = 0; i < K + 5; i++) step(1'b1, $urandom, 1'b1);
    chk("fresh_first_result", 128'(npop), 128'd1);
    chk("fresh_tap", coef_addr_o, 3'd5);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_in_ready", in_ready_o, 1'b0);
    chk("arst_coef_addr", coef_addr_o, 3'd0);
    chk("arst_out_valid", out_valid_o, 1'b0);
    chk("arst_out_data", out_data_o, '0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    reset_model();
    @(posedge clk); #1;
    start_run();
    guard = 0;
    while (npop < 2 && guard < 400) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      guard++;
    end
    chk("post_rst_results", 128'(npop), 128'd2);
    abort_i = 1'b1;
    @(posedge clk); #1;
    abort_i = 1'b0;
    chk("final_idle", busy_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
